board_scanner: RTL and testbench
================================

# board_scanner

Sequencer that checks the tic-tac-toe board for a winner and for a full board after every committed move. It walks the 8 winning lines (3 cells each) through the board memory's single read port, which it shares with the display logic via a request/grant handshake. It drives the `win` and `full` inputs consumed by `game_FSM`. Scan latency is fixed and deterministic, apart from grant stalls.

## Interface
- `ADDR_W`, 4: board cell address width (cells 0..8, row-major).
- `CELL_W`, 2: cell state width (0 empty, 1 player 1, 2 player 2, 3 invalid).
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-low.
- `start` in 1: scan request, sampled only in IDLE; pulse one cycle after a board write.
- `rd_req` out 1: scanner requests the board read port.
- `rd_gnt` in 1: read port granted this cycle for `rd_addr`.
- `rd_addr` out `ADDR_W`: cell address, valid while `rd_req`=1.
- `rd_data` in `CELL_W`: cell state, valid the cycle after a granted request.
- `busy` out 1: scan in progress.
- `done` out 1: one-cycle pulse when results update.
- `win` out 1: a line holds three equal player marks.
- `winner` out 2: winning player (1 or 2), 0 if `win`=0.
- `win_line` out 3: index of the reported winning line, 0 if `win`=0.
- `full` out 1: all 9 cells non-empty.

## Operation
- FSM states: IDLE, REQ, DATA, EVAL, DONE.
- IDLE: `busy`=0. On `start`=1:
  - clear line index L, cell index k, the occupancy mask and the pending-win registers;
  - go to REQ.
- REQ: `rd_req`=1, `rd_addr`=LINE_CELLS[L][k].
  - `rd_gnt`=1: go to DATA.
  - Otherwise stay in REQ with `rd_addr` held stable.
- DATA: capture `rd_data` into cell register k and set occupancy bit [addr] if `rd_data`≠0.
  - k<2: increment k, go to REQ.
  - k=2: go to EVAL.
- EVAL: line wins iff c0=c1=c2 and c0∈{1,2}.
  - Latch pending win/winner/line only if no win is already pending, so the first line in scan order wins.
  - Clear k. L<7: increment L, go to REQ. L=7: go to DONE.
- DONE: copy pending results to `win`/`winner`/`win_line`, set `full`=&occupancy, pulse `done`, go to IDLE.
- Line order: 0-2 rows {0,1,2},{3,4,5},{6,7,8}; 3-5 columns {0,3,6},{1,4,7},{2,5,8}; 6 diagonal {0,4,8}; 7 diagonal {2,4,6}.
- All 24 reads always happen; there is no early termination, so `full` is always exact.
- Outputs `win`/`winner`/`win_line`/`full` hold their previous values during a scan and change only in DONE.
- Cell value 3 counts as occupied but never as a winning mark.
- `start` while `busy`=1 is ignored; it is not queued.

## Timing
- Reset (`rst`=0 at a clock edge): state IDLE; all outputs 0, including `rd_req`, `rd_addr`, `done` and `busy`.
- Reset mid-scan aborts the scan with no `done` pulse and clears the results.
- With `rd_gnt` tied to 1:
  - each line takes 7 cycles (3×REQ/DATA + EVAL);
  - `start` sampled at cycle 0 puts REQ at cycle 1, the last EVAL at cycle 56, and DONE/`done` at cycle 57;
  - `busy` is high in cycles 1..57.
- Each cycle in REQ without a grant adds exactly one cycle of latency.
- `rd_data` is sampled exactly one cycle after the REQ cycle with `rd_gnt`=1. The arbiter must not be re-granted in DATA, because `rd_req`=0 there.
- `done`, `win` and `full` change together at the same edge.

## Structure
- Package `board_pkg`:
  - `cell_t` enum (EMPTY=0, P1=1, P2=2);
  - `NUM_CELLS`=9, `NUM_LINES`=8;
  - `LINE_CELLS` constant ROM [8][3] of 4-bit addresses;
  - FSM state enum.
- One sub-module `line_check`, combinational: three `cell_t` inputs → match flag + player.
- FSM, counters, occupancy mask and result registers live in `board_scanner`.

## Test plan
- Empty board, grant tied high, `start` pulse → `done` at cycle 57; `win`=0, `winner`=0, `full`=0.
- Row 1 (cells 3,4,5) = P1, rest empty → `win`=1, `winner`=1, `win_line`=1, `full`=0.
- Diagonal 2,4,6 = P2 → `win`=1, `winner`=2, `win_line`=7.
- Board 1,2,1 / 1,2,2 / 2,1,1 → `win`=0, `full`=1. Row 0 and column 0 both P1 → `win_line`=0.
- `rd_gnt` low for 5 cycles on the first REQ → `rd_addr`=0 held stable, `done` at cycle 62; a `start` during the scan is ignored.
- `rst`=0 at cycle 20 of a winning scan → next cycle all outputs 0 and `busy`=0; a later `start` completes a normal scan.

Source files
------------

// File: rtl/board_pkg.sv
// Shared types and constants for the tic-tac-toe board scanner.
// LINE_CELLS lists the three cell addresses of each winning line in scan order.
package board_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        P1    = 2'd1,
        P2    = 2'd2
    } cell_t;

    localparam int unsigned NUM_CELLS = 9;
    localparam int unsigned NUM_LINES = 8;

    // Rows 0-2, columns 3-5, main diagonal 6, anti-diagonal 7.
    localparam logic [3:0] LINE_CELLS [NUM_LINES][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StData,
        StEval,
        StDone
    } state_e;

endpackage

// File: rtl/line_check.sv
// Combinational test of one line: matches when all three cells hold the same player mark.
// The invalid value 3 never matches.
module line_check
    import board_pkg::*;
(
    input  cell_t       c0_i,
    input  cell_t       c1_i,
    input  cell_t       c2_i,
    output logic        match_o,
    output logic [1:0]  player_o
);

    always_comb begin
        match_o  = (c0_i == c1_i) && (c1_i == c2_i) && ((c0_i == P1) || (c0_i == P2));
        player_o = match_o ? c0_i : 2'd0;
    end

endmodule

// File: rtl/board_scanner.sv
// Walks the 8 winning lines through the shared board read port after each move and
// reports the first winning line in scan order plus whether the board is full.
module board_scanner
    import board_pkg::*;
#(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned CELL_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              rd_req,
    input  logic              rd_gnt,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [CELL_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              win,
    output logic [1:0]        winner,
    output logic [2:0]        win_line,
    output logic              full
);

    state_e                 state_q, state_d;
    logic [2:0]             line_q, line_d;
    logic [1:0]             k_q, k_d;
    cell_t                  cells_q [3];
    cell_t                  cells_d [3];
    logic [NUM_CELLS-1:0]   occ_q, occ_d;
    logic                   pend_win_q, pend_win_d;
    logic [1:0]             pend_winner_q, pend_winner_d;
    logic [2:0]             pend_line_q, pend_line_d;
    logic                   win_q, win_d;
    logic [1:0]             winner_q, winner_d;
    logic [2:0]             win_line_q, win_line_d;
    logic                   full_q, full_d;

    logic [3:0]             cur_addr;
    logic                   line_match;
    logic [1:0]             line_player;

    assign cur_addr = LINE_CELLS[line_q][k_q];

    line_check u_line_check (
        .c0_i     (cells_q[0]),
        .c1_i     (cells_q[1]),
        .c2_i     (cells_q[2]),
        .match_o  (line_match),
        .player_o (line_player)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= StIdle;
            line_q        <= '0;
            k_q           <= '0;
            cells_q       <= '{default: EMPTY};
            occ_q         <= '0;
            pend_win_q    <= 1'b0;
            pend_winner_q <= '0;
            pend_line_q   <= '0;
            win_q         <= 1'b0;
            winner_q      <= '0;
            win_line_q    <= '0;
            full_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            line_q        <= line_d;
            k_q           <= k_d;
            cells_q       <= cells_d;
            occ_q         <= occ_d;
            pend_win_q    <= pend_win_d;
            pend_winner_q <= pend_winner_d;
            pend_line_q   <= pend_line_d;
            win_q         <= win_d;
            winner_q      <= winner_d;
            win_line_q    <= win_line_d;
            full_q        <= full_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StReq;
            StReq:   if (rd_gnt) state_d = StData;
            StData:  state_d = (k_q == 2'd2) ? StEval : StReq;
            StEval:  state_d = (line_q == 3'd7) ? StDone : StReq;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        line_d        = line_q;
        k_d           = k_q;
        cells_d       = cells_q;
        occ_d         = occ_q;
        pend_win_d    = pend_win_q;
        pend_winner_d = pend_winner_q;
        pend_line_d   = pend_line_q;
        win_d         = win_q;
        winner_d      = winner_q;
        win_line_d    = win_line_q;
        full_d        = full_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    line_d        = '0;
                    k_d           = '0;
                    occ_d         = '0;
                    pend_win_d    = 1'b0;
                    pend_winner_d = '0;
                    pend_line_d   = '0;
                end
            end
            StData: begin
                cells_d[k_q] = cell_t'(rd_data);
                if (rd_data != '0) occ_d[cur_addr] = 1'b1;
                if (k_q != 2'd2) k_d = k_q + 2'd1;
            end
            StEval: begin
                if (!pend_win_q && line_match) begin
                    pend_win_d    = 1'b1;
                    pend_winner_d = line_player;
                    pend_line_d   = line_q;
                end
                k_d = '0;
                if (line_q != 3'd7) begin
                    line_d = line_q + 3'd1;
                end else begin
                    // Results land on the edge entering StDone so they rise together with done.
                    win_d      = pend_win_d;
                    winner_d   = pend_winner_d;
                    win_line_d = pend_line_d;
                    full_d     = &occ_q;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_req   = (state_q == StReq);
        rd_addr  = rd_req ? ADDR_W'(cur_addr) : '0;
        busy     = (state_q != StIdle);
        done     = (state_q == StDone);
        win      = win_q;
        winner   = winner_q;
        win_line = win_line_q;
        full     = full_q;
    end

endmodule

// File: tb/tb_board_scanner.sv
// Self-checking bench for board_scanner: table of boards with expected results, a
// board-memory responder with optional grant stalls, and hand-written reset/ignore sequences.
module tb_board_scanner;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       rd_req;
    logic       rd_gnt = 1'b1;
    logic [3:0] rd_addr;
    logic [1:0] rd_data = 2'd3;
    logic       busy, done, win, full;
    logic [1:0] winner;
    logic [2:0] win_line;

    board_scanner #(.ADDR_W(4), .CELL_W(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rd_req   (rd_req),
        .rd_gnt   (rd_gnt),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .busy     (busy),
        .done     (done),
        .win      (win),
        .winner   (winner),
        .win_line (win_line),
        .full     (full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [0:8][1:0] b;
        logic            win;
        logic [1:0]      winner;
        logic [2:0]      line;
        logic            full;
        int              stalls;
        int              lat;
        int              ignore_at;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    vec_t vecs[$];
    vec_t exp_q[$];

    logic [0:8][1:0] board = '0;
    int              stall_cnt = 0;
    logic            hit = 1'b0;
    logic [3:0]      hit_addr = '0;
    int              reads = 0;
    int              stall_bad = 0;

    logic            prev_win = 0;
    logic [1:0]      prev_winner = 0;
    logic [2:0]      prev_line = 0;
    logic            prev_full = 0;

    // Board memory: data appears the cycle after a granted request, 3 otherwise.
    always @(negedge clk) begin
        rd_data = (hit && hit_addr < 4'd9) ? board[hit_addr] : 2'd3;
        if (rd_req && stall_cnt > 0) begin
            rd_gnt = 1'b0;
            stall_cnt--;
            if (rd_addr != 4'd0) stall_bad++;
        end else begin
            rd_gnt = 1'b1;
        end
        hit      = rd_req && rd_gnt;
        hit_addr = rd_addr;
        if (hit) reads++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [0:8][1:0] b, input logic w, input logic [1:0] wn,
                                 input logic [2:0] ln, input logic f, input int st,
                                 input int lat, input int ign);
        vec_t v;
        v.b = b; v.win = w; v.winner = wn; v.line = ln; v.full = f;
        v.stalls = st; v.lat = lat; v.ignore_at = ign;
        return v;
    endfunction

    task automatic run_scan(input vec_t v, input string tag);
        int   cyc;
        vec_t e;
        board     = v.b;
        stall_cnt = v.stalls;
        reads     = 0;
        stall_bad = 0;
        exp_q.push_back(v);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 1;
        check({tag, " busy_c1"}, busy, 1);
        check({tag, " hold_win_c1"}, {win, winner, win_line, full},
              {prev_win, prev_winner, prev_line, prev_full});
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (v.ignore_at > 0 && cyc == v.ignore_at) start = 1'b1;
            else start = 1'b0;
            if (cyc == v.lat - 1)
                check({tag, " hold_before_done"}, {win, winner, win_line, full},
                      {prev_win, prev_winner, prev_line, prev_full});
        end
        start = 1'b0;
        if (!done) begin
            check({tag, " done_timeout"}, 0, 1);
            return;
        end
        e = exp_q.pop_front();
        check({tag, " done_cycle"}, cyc, e.lat);
        check({tag, " win"}, win, e.win);
        check({tag, " winner"}, winner, e.winner);
        check({tag, " win_line"}, win_line, e.line);
        check({tag, " full"}, full, e.full);
        check({tag, " reads"}, reads, 24);
        if (e.stalls > 0) check({tag, " stall_addr"}, stall_bad, 0);
        @(negedge clk);
        check({tag, " done_pulse"}, {done, busy}, 2'b00);
        @(negedge clk);
        check({tag, " no_requeue"}, busy, 0);
        prev_win = e.win; prev_winner = e.winner; prev_line = e.line; prev_full = e.full;
    endtask

    initial begin
        vecs.push_back(mkv({2'd0,2'd0,2'd0, 2'd0,2'd0,2'd0, 2'd0,2'd0,2'd0}, 0, 0, 0, 0, 0, 57, 0));
        vecs.push_back(mkv({2'd0,2'd0,2'd0, 2'd1,2'd1,2'd1, 2'd0,2'd0,2'd0}, 1, 1, 1, 0, 0, 57, 0));
        vecs.push_back(mkv({2'd0,2'd0,2'd2, 2'd0,2'd2,2'd0, 2'd2,2'd0,2'd0}, 1, 2, 7, 0, 0, 57, 0));
        vecs.push_back(mkv({2'd1,2'd2,2'd1, 2'd1,2'd2,2'd2, 2'd2,2'd1,2'd1}, 0, 0, 0, 1, 0, 57, 0));
        vecs.push_back(mkv({2'd1,2'd1,2'd1, 2'd1,2'd0,2'd0, 2'd1,2'd0,2'd0}, 1, 1, 0, 0, 0, 57, 0));
        vecs.push_back(mkv({2'd3,2'd3,2'd3, 2'd3,2'd3,2'd3, 2'd3,2'd3,2'd3}, 0, 0, 0, 1, 0, 57, 0));
        vecs.push_back(mkv({2'd1,2'd0,2'd0, 2'd0,2'd1,2'd0, 2'd0,2'd0,2'd1}, 1, 1, 6, 0, 0, 57, 0));
        vecs.push_back(mkv({2'd0,2'd0,2'd2, 2'd0,2'd2,2'd2, 2'd2,2'd0,2'd2}, 1, 2, 5, 0, 0, 57, 0));
        vecs.push_back(mkv({2'd0,2'd0,2'd0, 2'd0,2'd0,2'd0, 2'd0,2'd0,2'd0}, 0, 0, 0, 0, 5, 62, 20));
        vecs.push_back(mkv({2'd1,2'd1,2'd1, 2'd2,2'd2,2'd1, 2'd2,2'd1,2'd2}, 1, 1, 0, 1, 0, 57, 0));

        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {rd_req, rd_addr, done, busy, win, winner, win_line, full}, 0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) run_scan(vecs[i], $sformatf("vec%0d", i));

        // Abort a winning scan with reset at cycle 20; previous results are nonzero.
        begin
            int cyc;
            board = {2'd0,2'd0,2'd0, 2'd1,2'd1,2'd1, 2'd0,2'd0,2'd0};
            @(negedge clk) start = 1'b1;
            @(negedge clk) start = 1'b0;
            cyc = 1;
            while (cyc < 19) begin
                @(negedge clk);
                cyc++;
            end
            rst = 1'b0;
            @(negedge clk);
            check("rst_mid_outputs", {rd_req, rd_addr, done, busy, win, winner, win_line, full}, 0);
            rst = 1'b1;
            repeat (3) @(negedge clk);
            check("rst_mid_idle", {busy, done}, 2'b00);
            prev_win = 0; prev_winner = 0; prev_line = 0; prev_full = 0;
        end
        run_scan(vecs[1], "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
